uart_rx: RTL

Receive half of the 8-bit UART pair. It sits downstream of the serial line driven by `Uart_TX`. It deserialises one LSB-first frame into a parallel byte: start bit, DATA_BITS data bits, optional parity bit, then one stop bit. Each completed frame produces a single-cycle `rx_valid` strobe with error flags, and the byte goes to the consuming logic.

---
 rtl/uart_rx.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer and start/data/parity/stop FSM with a one-cycle rx_valid strobe.
// Optional build macro UART_RX_MAJORITY_EN selects 3-sample majority voting at every sample point.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int HALF       = BIT_PERIOD / 2;
    localparam logic [15:0] HALF_END = 16'(HALF - 1);
    localparam logic [15:0] BIT_END  = 16'(BIT_PERIOD - 1);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rxs;
    logic                 sample;
    logic [15:0]          cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx_in};
    end
    assign rxs = sync[1];

`ifdef UART_RX_MAJORITY_EN
    // Vote window is the current rxs plus the two previous values, so sample cycles do not move.
    logic [1:0] hist;
    always_ff @(posedge clk) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rxs};
    end
    assign sample = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample = rxs;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_busy    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: if (!rxs) begin
                    state   <= START;
                    cnt     <= '0;
                    rx_busy <= 1'b1;
                end
                START: if (cnt == HALF_END) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!sample) state <= DATA;
                    else begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end else cnt <= cnt + 16'd1;
                DATA: if (cnt == BIT_END) begin
                    cnt     <= '0;
                    shreg   <= {sample, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == LAST_BIT) state <= (PARITY != 0) ? PAR : STOP;
                end else cnt <= cnt + 16'd1;
                PAR: if (cnt == BIT_END) begin
                    cnt     <= '0;
                    par_bad <= (PARITY == 1) ? ~(^shreg ^ sample) : (^shreg ^ sample);
                    state   <= STOP;
                end else cnt <= cnt + 16'd1;
                STOP: if (cnt == BIT_END) begin
                    cnt        <= '0;
                    rx_data    <= shreg;
                    frame_err  <= ~sample;
                    parity_err <= par_bad;
                    rx_valid   <= 1'b1;
                    if (sample) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else state <= WAIT_HIGH;
                end else cnt <= cnt + 16'd1;
                // A held-low line (break) must not look like a new start bit.
                WAIT_HIGH: if (rxs) begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
